// File: rtl/nios_nios2_qsys_0_oci_pkg.sv
// Shared definitions for the Nios II on-chip instrumentation blocks:
// trace buffer geometry, jdo field positions and trace-memory command decode.
package nios_nios2_qsys_0_oci_pkg;

   localparam int TRC_DEPTH_LOG2 = 7;
   localparam int TRC_DATA_W     = 36;

   localparam int JDO_W         = 38;
   localparam int JDO_TRC_ON    = 4;
   localparam int JDO_TRC_CLR   = 3;
   localparam int JDO_WDATA_MSB = 35;
   localparam int JDO_WDATA_LSB = 0;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_TRACECTRL,
      CMD_MEM_WRITE,
      CMD_RD_LOAD,
      CMD_RD_ADVANCE
   } trc_cmd_e;

   // Strobes can coincide; only the highest-priority one is honoured.
   function automatic trc_cmd_e trc_cmd_decode(
      input logic tracectrl,
      input logic mem_write,
      input logic rd_load,
      input logic rd_advance
   );
      trc_cmd_e cmd;
      if (tracectrl)
         cmd = CMD_TRACECTRL;
      else if (mem_write)
         cmd = CMD_MEM_WRITE;
      else if (rd_load)
         cmd = CMD_RD_LOAD;
      else if (rd_advance)
         cmd = CMD_RD_ADVANCE;
      else
         cmd = CMD_NONE;
      return cmd;
   endfunction

endpackage

// File: rtl/nios_nios2_qsys_0_oci_trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// A read of the address being written returns the old contents.
module nios_nios2_qsys_0_oci_trace_ram #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 36
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Only the output register is cleared; array contents survive reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rd_data <= '0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/nios_nios2_qsys_0_oci_trace_buffer.sv
// Nios II on-chip trace buffer: circular capture of trace words with wrap flag,
// plus JTAG read/write access through a separate read pointer.
module nios_nios2_qsys_0_oci_trace_buffer
   import nios_nios2_qsys_0_oci_pkg::*;
#(
   parameter int DEPTH_LOG2 = TRC_DEPTH_LOG2,
   parameter int DATA_W     = TRC_DATA_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  trace_valid,
   input  logic [DATA_W-1:0]     trace_data,
   input  logic [37:0]           jdo,
   input  logic                  take_action_tracectrl,
   input  logic                  take_action_tracemem_a,
   input  logic                  take_action_tracemem_b,
   input  logic                  take_no_action_tracemem_a,
   output logic                  trc_on,
   output logic                  tracemem_on,
   output logic [DEPTH_LOG2-1:0] trc_im_addr,
   output logic                  trc_wrap,
   output logic                  tracemem_tw,
   output logic [DATA_W-1:0]     tracemem_trcdata
);

   trc_cmd_e              cmd;
   logic                  trc_clr;
   logic                  capture;
   logic                  jtag_wr;
   logic [DEPTH_LOG2-1:0] rd_addr;
   logic                  wr_en;
   logic [DEPTH_LOG2-1:0] wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic [DATA_W-1:0]     jtag_wdata;

   // A JTAG write during capture is dropped before arbitration, so it never
   // shadows a lower-priority pointer command.
   assign cmd = trc_cmd_decode(take_action_tracectrl,
                               take_action_tracemem_b & ~trc_on,
                               take_action_tracemem_a,
                               take_no_action_tracemem_a);

   assign trc_clr    = (cmd == CMD_TRACECTRL) && jdo[JDO_TRC_CLR];
   assign capture    = trc_on & trace_valid & ~trc_clr;
   assign jtag_wr    = (cmd == CMD_MEM_WRITE);
   assign jtag_wdata = DATA_W'(jdo[JDO_WDATA_MSB:JDO_WDATA_LSB]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trc_on      <= 1'b0;
         trc_im_addr <= '0;
         trc_wrap    <= 1'b0;
      end else begin
         if (cmd == CMD_TRACECTRL)
            trc_on <= jdo[JDO_TRC_ON];
         if (trc_clr) begin
            trc_im_addr <= '0;
            trc_wrap    <= 1'b0;
         end else if (capture) begin
            trc_im_addr <= trc_im_addr + 1'b1;
            if (&trc_im_addr)
               trc_wrap <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr <= '0;
      end else begin
         case (cmd)
            CMD_MEM_WRITE,
            CMD_RD_ADVANCE: rd_addr <= rd_addr + 1'b1;
            CMD_RD_LOAD:    rd_addr <= jdo[DEPTH_LOG2-1:0];
            default:        rd_addr <= rd_addr;
         endcase
      end
   end

   // Capture and JTAG write are mutually exclusive through trc_on.
   always_comb begin
      wr_en   = capture | jtag_wr;
      wr_addr = rd_addr;
      wr_data = jtag_wdata;
      if (capture) begin
         wr_addr = trc_im_addr;
         wr_data = trace_data;
      end
   end

   nios_nios2_qsys_0_oci_trace_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (DATA_W)
   ) u_trace_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (tracemem_trcdata)
   );

   assign tracemem_on = trc_on;
   assign tracemem_tw = trc_wrap;

endmodule

// File: tb/tb_nios_nios2_qsys_0_oci_trace_buffer.sv
// Directed testbench for the Nios II OCI trace buffer.
module tb_nios_nios2_qsys_0_oci_trace_buffer;

   logic        clk;
   logic        reset_n;
   logic        trace_valid;
   logic [35:0] trace_data;
   logic [37:0] jdo;
   logic        take_action_tracectrl;
   logic        take_action_tracemem_a;
   logic        take_action_tracemem_b;
   logic        take_no_action_tracemem_a;
   logic        trc_on;
   logic        tracemem_on;
   logic [6:0]  trc_im_addr;
   logic        trc_wrap;
   logic        tracemem_tw;
   logic [35:0] tracemem_trcdata;

   int n_cmp = 0;
   int n_err = 0;

   nios_nios2_qsys_0_oci_trace_buffer dut (
      .clk                       (clk),
      .reset_n                   (reset_n),
      .trace_valid               (trace_valid),
      .trace_data                (trace_data),
      .jdo                       (jdo),
      .take_action_tracectrl     (take_action_tracectrl),
      .take_action_tracemem_a    (take_action_tracemem_a),
      .take_action_tracemem_b    (take_action_tracemem_b),
      .take_no_action_tracemem_a (take_no_action_tracemem_a),
      .trc_on                    (trc_on),
      .tracemem_on               (tracemem_on),
      .trc_im_addr               (trc_im_addr),
      .trc_wrap                  (trc_wrap),
      .tracemem_tw               (tracemem_tw),
      .tracemem_trcdata          (tracemem_trcdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      take_action_tracectrl     = 1'b0;
      take_action_tracemem_a    = 1'b0;
      take_action_tracemem_b    = 1'b0;
      take_no_action_tracemem_a = 1'b0;
      trace_valid               = 1'b0;
      jdo                       = '0;
   endtask

   task automatic tracectrl(input logic [37:0] j);
      take_action_tracectrl = 1'b1;
      jdo = j;
      tick();
      idle();
   endtask

   // Load rd_addr, then wait one more edge for the registered read.
   task automatic read_at(input logic [6:0] a);
      take_action_tracemem_a = 1'b1;
      jdo = {31'd0, a};
      tick();
      idle();
      tick();
   endtask

   initial begin
      reset_n    = 1'b0;
      trace_data = '0;
      idle();

      // Reset state
      tick();
      tick();
      check("rst_trc_on", trc_on, 0);
      check("rst_tracemem_on", tracemem_on, 0);
      check("rst_im_addr", trc_im_addr, 0);
      check("rst_wrap", trc_wrap, 0);
      check("rst_tw", tracemem_tw, 0);
      check("rst_trcdata", tracemem_trcdata, 0);
      reset_n = 1'b1;

      // Capture disabled after reset
      trace_valid = 1'b1;
      trace_data  = 36'h5_5555_5555;
      tick();
      tick();
      idle();
      check("off_no_capture", trc_im_addr, 0);

      // Capture five words and read back
      tracectrl(38'h18);
      check("on_trc_on", trc_on, 1);
      check("on_tracemem_on", tracemem_on, 1);
      for (int i = 0; i < 5; i++) begin
         trace_valid = 1'b1;
         trace_data  = 36'h1_0000_000A + 36'(i);
         tick();
      end
      idle();
      check("cap5_addr", trc_im_addr, 5);
      check("cap5_wrap", trc_wrap, 0);
      tracectrl(38'h0);
      check("off_trc_on", trc_on, 0);
      read_at(7'd2);
      check("read_2", tracemem_trcdata, 36'h1_0000_000C);
      take_no_action_tracemem_a = 1'b1;
      tick();
      idle();
      tick();
      check("advance_3", tracemem_trcdata, 36'h1_0000_000D);

      // Wrap: 130 words
      tracectrl(38'h18);
      for (int i = 0; i < 130; i++) begin
         trace_valid = 1'b1;
         trace_data  = 36'h2_0000_0000 + 36'(i);
         tick();
         if (i == 126) check("wrap_before", trc_wrap, 0);
         if (i == 127) check("wrap_addr0", trc_im_addr, 0);
         if (i >= 127) begin
            check("wrap_set", trc_wrap, 1);
            check("wrap_tw", tracemem_tw, 1);
         end
      end
      idle();
      check("wrap_addr2", trc_im_addr, 2);
      tracectrl(38'h0);
      read_at(7'd0);
      check("wrap_mem0", tracemem_trcdata, 36'h2_0000_0080);
      read_at(7'd2);
      check("wrap_mem2_old", tracemem_trcdata, 36'h2_0000_0002);

      // Clear plus capture in the same cycle: clear wins, word dropped
      tracectrl(38'h10);
      check("reon_addr_kept", trc_im_addr, 2);
      take_action_tracectrl = 1'b1;
      jdo         = 38'h18;
      trace_valid = 1'b1;
      trace_data  = 36'hF_FFFF_FFFF;
      tick();
      idle();
      check("clr_cap_addr", trc_im_addr, 0);
      check("clr_cap_wrap", trc_wrap, 0);
      check("clr_cap_on", trc_on, 1);
      tracectrl(38'h0);
      read_at(7'd2);
      check("clr_cap_dropped", tracemem_trcdata, 36'h2_0000_0002);

      // JTAG write with capture off: writes mem[127], rd_addr wraps to 0
      take_action_tracemem_a = 1'b1;
      jdo = 38'h7F;
      tick();
      idle();
      take_action_tracemem_b = 1'b1;
      jdo = 38'hA_BCDE_F012;
      tick();
      idle();
      check("jwr_rbw", tracemem_trcdata, 36'h2_0000_007F);
      tick();
      check("jwr_ptr_wrap", tracemem_trcdata, 36'h2_0000_0080);
      read_at(7'h7F);
      check("jwr_data", tracemem_trcdata, 36'hA_BCDE_F012);

      // JTAG write with capture on: ignored, pointer unchanged
      tracectrl(38'h10);
      take_action_tracemem_a = 1'b1;
      jdo = 38'h7E;
      tick();
      idle();
      take_action_tracemem_b = 1'b1;
      jdo = 38'h1234;
      tick();
      idle();
      tick();
      check("jwr_on_ignored", tracemem_trcdata, 36'h2_0000_007E);
      tracectrl(38'h0);

      // Load and advance together: load wins
      take_action_tracemem_a    = 1'b1;
      take_no_action_tracemem_a = 1'b1;
      jdo = 38'h5;
      tick();
      idle();
      tick();
      check("load_beats_adv", tracemem_trcdata, 36'h2_0000_0005);

      // Reset mid-capture
      tracectrl(38'h18);
      trace_valid = 1'b1;
      trace_data  = 36'h3_0000_0001;
      tick();
      tick();
      check("pre_rst_addr", trc_im_addr, 2);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_trc_on", trc_on, 0);
      check("midrst_tracemem_on", tracemem_on, 0);
      check("midrst_addr", trc_im_addr, 0);
      check("midrst_wrap", trc_wrap, 0);
      check("midrst_tw", tracemem_tw, 0);
      check("midrst_trcdata", tracemem_trcdata, 0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      tick();
      check("postrst_no_capture", trc_im_addr, 0);
      check("postrst_off", trc_on, 0);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nios_nios2_qsys_0_oci_trace_buffer.md
# nios_nios2_qsys_0_oci_trace_buffer

On-chip trace buffer for the Nios II debug module. It captures 36-bit trace words from the CPU trace packetizer into a circular RAM and reports the capture pointer and wrap status. The JTAG debug-module wrapper reads the buffer back, and can also write it, using the `jdo` bus and the `take_*action_tracemem*` strobes that the wrapper produces. This block sits directly upstream of the wrapper and drives its `tracemem_*` and `trc_*` inputs.

## Interface
Parameters:
- `DEPTH_LOG2`, default 7: log2 of the buffer depth (128 entries).
- `DATA_W`, default 36: width of one trace word.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `trace_valid`, in, 1: a trace word is present this cycle.
- `trace_data`, in, DATA_W: the trace word.
- `jdo`, in, 38: JTAG data-out bus from the debug wrapper.
- `take_action_tracectrl`, in, 1: trace-control command strobe.
- `take_action_tracemem_a`, in, 1: load the read pointer.
- `take_action_tracemem_b`, in, 1: JTAG write to the buffer.
- `take_no_action_tracemem_a`, in, 1: advance the read pointer.
- `trc_on`, out, 1: capture enabled.
- `tracemem_on`, out, 1: equals `trc_on`.
- `trc_im_addr`, out, DEPTH_LOG2: capture write pointer.
- `trc_wrap`, out, 1: sticky flag, set once the buffer has wrapped.
- `tracemem_tw`, out, 1: equals `trc_wrap`.
- `tracemem_trcdata`, out, DATA_W: registered read data at the read pointer.

## Operation
- **Reset:** `trc_on`, `trc_im_addr`, `trc_wrap`, the read pointer `rd_addr` and `tracemem_trcdata` all reset to 0. RAM contents are not reset.
- **Trace control** (`take_action_tracectrl`):
  - `trc_on` <= `jdo[4]`.
  - If `jdo[3]`=1, `trc_im_addr` <= 0 and `trc_wrap` <= 0.
- **Capture** (`trc_on` & `trace_valid`):
  - Write `mem[trc_im_addr]` <= `trace_data`.
  - `trc_im_addr` increments modulo 2^DEPTH_LOG2.
  - On the increment from all-ones to 0, `trc_wrap` <= 1.
- **Read pointer load** (`take_action_tracemem_a`): `rd_addr` <= `jdo[DEPTH_LOG2-1:0]`.
- **Read pointer advance** (`take_no_action_tracemem_a`): `rd_addr` increments modulo depth and wraps silently.
- **JTAG write** (`take_action_tracemem_b`):
  - Only while `trc_on`=0: `mem[rd_addr]` <= `jdo[35:0]`, then `rd_addr` increments.
  - While `trc_on`=1 the strobe is ignored entirely.
- **Read port:** every cycle, `tracemem_trcdata` <= `mem[rd_addr]`. Read-before-write: the same-cycle write data is not returned.
- **Command priority**, when strobes coincide: `tracectrl` > `tracemem_b` > `tracemem_a` > `no_action_tracemem_a`. Only the winning command acts.
- **Simultaneous events:**
  - Pointer clear plus capture in the same cycle: the clear wins and the word is dropped.
  - `tracectrl` setting `trc_on`: capture starts the following cycle.
  - Capture and JTAG write can never collide, because of the `trc_on` gating.
- **Reset mid-capture:** pointers, flags and `trc_on` clear immediately. RAM keeps stale data, and the host treats it as invalid until `trc_wrap` or `trc_im_addr` show fresh content.

## Timing
- Capture at edge N: the `trc_im_addr` increment is visible after edge N. The word is readable at `tracemem_trcdata` 1 cycle after `rd_addr` points at it.
- Read latency: `rd_addr` updates at edge N, and `tracemem_trcdata` is valid after edge N+1.
- `trc_wrap` asserts in the same cycle that `trc_im_addr` shows 0 after a wrap.
- `tracemem_on` and `tracemem_tw` are combinational copies with zero latency.
- All outputs are registered except those two copies.

## Structure
- **Shared package** `nios_nios2_qsys_0_oci_pkg` holds:
  - `TRC_DEPTH_LOG2` and `TRC_DATA_W`.
  - The `jdo` field positions: `JDO_TRC_ON`=4, `JDO_TRC_CLR`=3, `JDO_WDATA` [35:0].
- **Sub-module** `nios_nios2_qsys_0_oci_trace_ram`: simple dual-port RAM with one write port (capture and JTAG data muxed onto it) and one registered read port, read-before-write.
- **Top level:** pointers, flags, command priority decode and write mux.

## Test plan
- **Reset:** assert `reset_n`=0 mid-capture -> all outputs are 0 immediately. After release, `trc_on`=0 and no capture occurs on `trace_valid`.
- **Capture and read-back:**
  - Stimulus: tracectrl with `jdo`=0x18 (on and clear), then 5 `trace_valid` words 0x1_0000_000A..0E.
  - Required: `trc_im_addr`=5, `trc_wrap`=0.
  - Then tracectrl with `jdo`=0 (off), `tracemem_a` with `jdo`=2 -> 2 cycles later `trcdata`=0x1_0000_000C. One `no_action` -> 0x1_0000_000D.
- **Wrap:** 130 captured words -> `trc_wrap`=`tracemem_tw`=1 from word 128 onward, `trc_im_addr`=2, and `mem[0]` holds word 128.
- **JTAG write:**
  - With `trc_on`=0: `tracemem_a` with `jdo`=0x7F, then `tracemem_b` with `jdo`=0xA_BCDE_F012 -> `mem[127]` is written and `rd_addr` wraps to 0.
  - Repeat with `trc_on`=1 -> no write, pointer unchanged.
- **Simultaneous:** tracectrl clear plus `trace_valid` in the same cycle -> `trc_im_addr`=0 and the word is dropped. `tracemem_a` plus `no_action_tracemem_a` together -> the load wins.
